// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_pkg
// Description : Shared types and elaboration-time helpers for the pipelined
//               mux tree (tree depth and per-level node counts).
// Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    // Source of the lane index for a new sample.
    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mux_mode_e;

    // Number of 4:1 levels needed to cover n leaves, i.e. ceil(log4(n)).
    function automatic int clog4(input int n);
        int l;
        int p;
        l = 0;
        p = 1;
        while (p < n) begin
            p = p * 4;
            l = l + 1;
        end
        return l;
    endfunction

    // Number of 4:1 muxes at tree level lvl for n leaves.
    function automatic int mux_nodes(input int n, input int lvl);
        int span;
        span = 1 << (2 * (lvl + 1));
        return (n + span - 1) / span;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_tree_stage.sv
`default_nettype none
// ============================================================================
// Module      : mux_tree_stage
// Description : One registered level of 4:1 muxes. Carries the valid, index
//               and error sidecar alongside the data and holds when disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_tree_stage #(
    parameter int WIDTH   = 8,
    parameter int N_NODES = 1,
    parameter int SEL_W   = 4,
    parameter int LEVEL   = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en_i,
    input  logic                       valid_i,
    input  logic [SEL_W-1:0]           idx_i,
    input  logic                       err_i,
    input  logic [N_NODES*4*WIDTH-1:0] data_i,
    output logic                       valid_o,
    output logic [SEL_W-1:0]           idx_o,
    output logic                       err_o,
    output logic [N_NODES*WIDTH-1:0]   data_o
);

    logic [1:0]               w_sel;
    logic [N_NODES*WIDTH-1:0] data_d;
    logic [N_NODES*WIDTH-1:0] data_q;
    logic                     valid_q;
    logic [SEL_W-1:0]         idx_q;
    logic                     err_q;

    // Each level consumes its own pair of index bits.
    assign w_sel = idx_i[2*LEVEL +: 2];

    // Pick one of four children per node; an out-of-range index yields zero.
    always_comb begin
        data_d = '0;
        for (int n = 0; n < N_NODES; n++) begin
            data_d[n*WIDTH +: WIDTH] = data_i[(n*4 + int'(w_sel))*WIDTH +: WIDTH];
        end
        if (err_i) begin
            data_d = '0;
        end
    end

    // Level register: loads on enable, otherwise holds for backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else if (en_i) begin
            data_q  <= data_d;
            valid_q <= valid_i;
            idx_q   <= idx_i;
            err_q   <= err_i;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign idx_o   = idx_q;
    assign err_o   = err_q;

endmodule
`default_nettype wire

// File: rtl/mux_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mux_tree_pipe
// Description : Pipelined N_IN:1 mux tree of WIDTH-bit lanes with valid/ready
//               handshake, whole-pipe backpressure and an internal scan
//               counter that steps through the lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_tree_pipe
    import mux_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int N_IN   = 16,
    localparam int LEVELS = clog4(N_IN),
    localparam int SEL_W  = 2 * LEVELS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_IN*WIDTH-1:0] in_data_i,
    input  logic [SEL_W-1:0]      sel_i,
    input  logic                  scan_en_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [WIDTH-1:0]      out_data_o,
    output logic [SEL_W-1:0]      out_idx_o,
    output logic                  out_err_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i
);

    mux_mode_e        w_mode;
    logic             w_stall;
    logic             w_accept;
    logic [SEL_W-1:0] w_idx;
    logic             w_err;
    logic [SEL_W-1:0] scan_cnt_d;
    logic [SEL_W-1:0] scan_cnt_q;

    assign w_mode     = scan_en_i ? MODE_SCAN : MODE_DIRECT;
    // The whole pipe freezes while the consumer refuses a valid beat.
    assign w_stall    = out_valid_o & ~out_ready_i;
    assign in_ready_o = ~w_stall;
    assign w_accept   = in_valid_i & in_ready_o;
    assign w_idx      = (w_mode == MODE_SCAN) ? scan_cnt_q : sel_i;
    assign w_err      = 32'(w_idx) >= 32'(N_IN);

    // Scan counter steps only on accepted scan samples and wraps at N_IN-1.
    always_comb begin
        scan_cnt_d = scan_cnt_q;
        if (w_accept && (w_mode == MODE_SCAN)) begin
            if (scan_cnt_q == SEL_W'(N_IN - 1)) begin
                scan_cnt_d = '0;
            end else begin
                scan_cnt_d = scan_cnt_q + SEL_W'(1);
            end
        end
    end

    // Scan counter register; survives mode switches, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
        end else begin
            scan_cnt_q <= scan_cnt_d;
        end
    end

    genvar j;
    generate
        for (j = 0; j < LEVELS; j++) begin : g_lvl
            localparam int NN = mux_nodes(N_IN, j);

            logic [NN*4*WIDTH-1:0] w_in;
            logic [NN*WIDTH-1:0]   w_out;
            logic                  w_vin;
            logic                  w_vout;
            logic [SEL_W-1:0]      w_iin;
            logic [SEL_W-1:0]      w_iout;
            logic                  w_ein;
            logic                  w_eout;

            if (j == 0) begin : g_head
                // Leaves past N_IN are zero-padded so they read as 0.
                assign w_in  = (NN*4*WIDTH)'(in_data_i);
                assign w_vin = in_valid_i;
                assign w_iin = w_idx;
                assign w_ein = w_err;
            end else begin : g_link
                assign w_in  = (NN*4*WIDTH)'(g_lvl[j-1].w_out);
                assign w_vin = g_lvl[j-1].w_vout;
                assign w_iin = g_lvl[j-1].w_iout;
                assign w_ein = g_lvl[j-1].w_eout;
            end

            mux_tree_stage #(
                .WIDTH   (WIDTH),
                .N_NODES (NN),
                .SEL_W   (SEL_W),
                .LEVEL   (j)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .en_i    (~w_stall),
                .valid_i (w_vin),
                .idx_i   (w_iin),
                .err_i   (w_ein),
                .data_i  (w_in),
                .valid_o (w_vout),
                .idx_o   (w_iout),
                .err_o   (w_eout),
                .data_o  (w_out)
            );
        end
    endgenerate

    assign out_data_o  = g_lvl[LEVELS-1].w_out;
    assign out_valid_o = g_lvl[LEVELS-1].w_vout;
    assign out_idx_o   = g_lvl[LEVELS-1].w_iout;
    assign out_err_o   = g_lvl[LEVELS-1].w_eout;

endmodule
`default_nettype wire

// File: tb/tb_mux_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_tree_pipe
// Description : Directed self-checking bench for mux_tree_pipe: a 16-lane
//               instance for datapath, handshake and scan behaviour, and a
//               10-lane instance for out-of-range and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_tree_pipe;

    logic clk;
    int   errors;
    int   checks;

    // 16-lane instance
    logic         rst_n_a;
    logic [127:0] a_in_data;
    logic [3:0]   a_sel;
    logic         a_scan_en;
    logic         a_in_valid;
    logic         a_in_ready;
    logic [7:0]   a_out_data;
    logic [3:0]   a_out_idx;
    logic         a_out_err;
    logic         a_out_valid;
    logic         a_out_ready;

    // 10-lane instance
    logic         rst_n_b;
    logic [79:0]  b_in_data;
    logic [3:0]   b_sel;
    logic         b_scan_en;
    logic         b_in_valid;
    logic         b_in_ready;
    logic [7:0]   b_out_data;
    logic [3:0]   b_out_idx;
    logic         b_out_err;
    logic         b_out_valid;
    logic         b_out_ready;

    mux_tree_pipe #(.WIDTH(8), .N_IN(16)) u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n_a),
        .in_data_i   (a_in_data),
        .sel_i       (a_sel),
        .scan_en_i   (a_scan_en),
        .in_valid_i  (a_in_valid),
        .in_ready_o  (a_in_ready),
        .out_data_o  (a_out_data),
        .out_idx_o   (a_out_idx),
        .out_err_o   (a_out_err),
        .out_valid_o (a_out_valid),
        .out_ready_i (a_out_ready)
    );

    mux_tree_pipe #(.WIDTH(8), .N_IN(10)) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n_b),
        .in_data_i   (b_in_data),
        .sel_i       (b_sel),
        .scan_en_i   (b_scan_en),
        .in_valid_i  (b_in_valid),
        .in_ready_o  (b_in_ready),
        .out_data_o  (b_out_data),
        .out_idx_o   (b_out_idx),
        .out_err_o   (b_out_err),
        .out_valid_o (b_out_valid),
        .out_ready_i (b_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        a_in_data = '0; a_sel = '0; a_scan_en = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        b_in_data = '0; b_sel = '0; b_scan_en = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
        for (int k = 0; k < 16; k++) a_in_data[k*8 +: 8] = 8'h10 + 8'(k);
        for (int k = 0; k < 10; k++) b_in_data[k*8 +: 8] = 8'h20 + 8'(k);
        #2;
        checks++;
        if (a_out_valid !== 1'b0 || a_out_data !== 8'h00 || a_out_idx !== 4'h0 || a_out_err !== 1'b0)
            begin errors++; $display("FAIL reset_outputs: valid=%b data=%h idx=%h err=%b, want 0 0 0 0",
                                     a_out_valid, a_out_data, a_out_idx, a_out_err); end
        checks++;
        if (a_in_ready !== 1'b1)
            begin errors++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
        tick();
        tick();
        #2;
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        tick();
        checks++;
        if (a_out_valid !== 1'b0)
            begin errors++; $display("FAIL reset_release_idle: out_valid=%b want 0", a_out_valid); end
    endtask

    task automatic test_direct();
        a_sel = 4'd5; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        checks++;
        if (a_out_valid !== 1'b0)
            begin errors++; $display("FAIL direct_early: out_valid=%b after 1 cycle want 0", a_out_valid); end
        tick();
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 8'h15 || a_out_idx !== 4'd5 || a_out_err !== 1'b0)
            begin errors++; $display("FAIL direct_beat: valid=%b data=%h idx=%0d err=%b want 1 15 5 0",
                                     a_out_valid, a_out_data, a_out_idx, a_out_err); end
        tick();
        checks++;
        if (a_out_valid !== 1'b0)
            begin errors++; $display("FAIL direct_single: out_valid=%b want 0", a_out_valid); end
    endtask

    task automatic test_back_to_back();
        int got;
        logic [7:0] ed;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            a_in_valid = (c < 16);
            a_sel = 4'(c);
            tick();
            if (a_out_valid) begin
                ed = 8'h10 + 8'(got);
                checks++;
                if (a_out_data !== ed || a_out_idx !== 4'(got))
                    begin errors++; $display("FAIL b2b_beat%0d: data=%h idx=%0d want %h %0d",
                                             got, a_out_data, a_out_idx, ed, got); end
                got++;
            end else if (got > 0 && got < 16) begin
                checks++;
                errors++;
                $display("FAIL b2b_gap: no beat at cycle %0d after %0d beats, want continuous", c, got);
            end
        end
        a_in_valid = 1'b0;
        checks++;
        if (got !== 16)
            begin errors++; $display("FAIL b2b_count: got %0d beats want 16", got); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_d [0:1];
        int got;
        exp_d[0] = 8'h14;
        exp_d[1] = 8'h15;
        a_in_valid = 1'b1; a_sel = 4'd3;
        tick();
        a_sel = 4'd4;
        tick();
        a_sel = 4'd5;
        a_out_ready = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_data !== 8'h13 || a_out_idx !== 4'd3)
                begin errors++; $display("FAIL stall_hold%0d: ready=%b valid=%b data=%h idx=%0d want 0 1 13 3",
                                         c, a_in_ready, a_out_valid, a_out_data, a_out_idx); end
            tick();
        end
        a_out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 0) a_in_valid = 1'b0;
            if (a_out_valid) begin
                checks++;
                if (got >= 2) begin
                    errors++; $display("FAIL stall_extra: unexpected beat data=%h", a_out_data);
                end else if (a_out_data !== exp_d[got]) begin
                    errors++; $display("FAIL stall_drain%0d: data=%h want %h", got, a_out_data, exp_d[got]);
                end
                got++;
            end
        end
        checks++;
        if (got !== 2)
            begin errors++; $display("FAIL stall_count: got %0d beats after release want 2", got); end
    endtask

    task automatic test_scan();
        logic [3:0] exp_i [0:19];
        logic [7:0] ed;
        int got;
        for (int i = 0; i < 16; i++) exp_i[i] = 4'(i);
        exp_i[16] = 4'd0; exp_i[17] = 4'd1; exp_i[18] = 4'd9; exp_i[19] = 4'd2;
        got = 0;
        for (int c = 0; c < 26; c++) begin
            if (c < 18) begin
                a_scan_en = 1'b1; a_in_valid = 1'b1; a_sel = 4'd15;
            end else if (c == 18) begin
                a_scan_en = 1'b0; a_in_valid = 1'b1; a_sel = 4'd9;
            end else if (c == 19) begin
                a_scan_en = 1'b1; a_in_valid = 1'b1; a_sel = 4'd15;
            end else begin
                a_in_valid = 1'b0;
            end
            tick();
            if (a_out_valid) begin
                checks++;
                if (got >= 20) begin
                    errors++; $display("FAIL scan_extra: unexpected beat idx=%0d", a_out_idx);
                end else begin
                    ed = 8'h10 + {4'h0, exp_i[got]};
                    if (a_out_idx !== exp_i[got] || a_out_data !== ed)
                        begin errors++; $display("FAIL scan_beat%0d: idx=%0d data=%h want %0d %h",
                                                 got, a_out_idx, a_out_data, exp_i[got], ed); end
                end
                got++;
            end
        end
        a_scan_en = 1'b0;
        checks++;
        if (got !== 20)
            begin errors++; $display("FAIL scan_count: got %0d beats want 20", got); end
    endtask

    task automatic test_capture();
        a_in_data[7*8 +: 8] = 8'hAA;
        a_sel = 4'd7; a_in_valid = 1'b1;
        tick();
        a_in_data[7*8 +: 8] = 8'hBB;
        a_in_valid = 1'b0;
        tick();
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 8'hAA || a_out_idx !== 4'd7)
            begin errors++; $display("FAIL capture: valid=%b data=%h idx=%0d want 1 AA 7",
                                     a_out_valid, a_out_data, a_out_idx); end
        a_in_data[7*8 +: 8] = 8'h17;
        tick();
    endtask

    task automatic test_out_of_range();
        b_sel = 4'd12; b_in_valid = 1'b1;
        tick();
        b_sel = 4'd9;
        tick();
        b_in_valid = 1'b0;
        checks++;
        if (b_out_valid !== 1'b1 || b_out_err !== 1'b1 || b_out_data !== 8'h00 || b_out_idx !== 4'd12)
            begin errors++; $display("FAIL oor_err: valid=%b err=%b data=%h idx=%0d want 1 1 00 12",
                                     b_out_valid, b_out_err, b_out_data, b_out_idx); end
        tick();
        checks++;
        if (b_out_valid !== 1'b1 || b_out_err !== 1'b0 || b_out_data !== 8'h29 || b_out_idx !== 4'd9)
            begin errors++; $display("FAIL oor_last_lane: valid=%b err=%b data=%h idx=%0d want 1 0 29 9",
                                     b_out_valid, b_out_err, b_out_data, b_out_idx); end
        tick();
    endtask

    task automatic test_reset_mid();
        b_sel = 4'd1; b_in_valid = 1'b1;
        tick();
        b_sel = 4'd2;
        tick();
        checks++;
        if (b_out_valid !== 1'b1 || b_out_data !== 8'h21)
            begin errors++; $display("FAIL rst_pre: valid=%b data=%h want 1 21", b_out_valid, b_out_data); end
        #2;
        rst_n_b = 1'b0;
        #1;
        checks++;
        if (b_out_valid !== 1'b0 || b_out_data !== 8'h00 || b_out_idx !== 4'd0)
            begin errors++; $display("FAIL rst_async: valid=%b data=%h idx=%0d want 0 00 0",
                                     b_out_valid, b_out_data, b_out_idx); end
        tick();
        b_in_valid = 1'b0;
        #2;
        rst_n_b = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (b_out_valid !== 1'b0)
                begin errors++; $display("FAIL rst_stale%0d: out_valid=%b data=%h want no beat",
                                         c, b_out_valid, b_out_data); end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_direct();
        test_back_to_back();
        tick();
        tick();
        test_backpressure();
        test_scan();
        test_capture();
        test_out_of_range();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
